mem_map_controller: RTL and testbench



---
 rtl/mem_map_controller_if.sv | 32 +++
 rtl/mem_map_controller.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_map_controller.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_map_controller_if.sv
// mem_map_controller_if: CPU-side bus between a bus master and the memory map
// controller.
//   req      master -> slave  read request, sampled with addr
//   we       master -> slave  write request
//   vf       master -> slave  vector-write flag, forwarded to the RAM
//   addr     master -> slave  CPU word address (DW bits)
//   wd       master -> slave  write data (DW bits)
//   rd       slave -> master  read data, zero when rd_valid is low
//   rd_valid slave -> master  read data qualifier, one cycle after the request
//   err      slave -> master  one-cycle access-error pulse
interface mem_map_controller_if #(
    parameter int DW = 128
);
    logic          req;
    logic          we;
    logic          vf;
    logic [DW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
    logic          rd_valid;
    logic          err;

    modport master (
        output req, we, vf, addr, wd,
        input  rd, rd_valid, err
    );

    modport slave (
        input  req, we, vf, addr, wd,
        output rd, rd_valid, err
    );
endinterface

// File: rtl/mem_map_controller.sv
// mem_map_controller: decodes CPU word addresses onto a ROM, a RAM and a bank of
// debounced switch registers. Every read answers exactly one cycle after it is
// requested; writes are forwarded combinationally to the RAM.
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   bus         CPU-side bus (slave modport): req/we/vf/addr/wd in, rd/rd_valid/err out
//   sw_i        raw asynchronous switch inputs, bit i = switch i
//   rom_addr_o  ROM-local address (0 outside the ROM window)
//   rom_rd_i    ROM read data, one-cycle synchronous read
//   ram_addr_o  RAM-local address (0 outside the RAM window)
//   ram_we_o    RAM write enable, only for writes inside the RAM window
//   ram_vf_o    vector-write flag forwarded to the RAM
//   ram_wd_o    RAM write data
//   ram_rd_i    RAM read data, one-cycle synchronous read
// IO window layout (word offsets from IO_BASE):
//   0 .. NSW-1        debounced switch i in bit 0
//   NSW .. 2*NSW-1    sticky rising-edge bit i in bit 0, cleared by the read
//   2*NSW             all debounced switches packed in bits NSW-1:0
module mem_map_controller #(
    parameter int DW          = 128,
    parameter int ROM_BASE    = 0,
    parameter int ROM_SIZE    = 120000,
    parameter int RAM_BASE    = 120000,
    parameter int RAM_SIZE    = 121000,
    parameter int IO_BASE     = 241000,
    parameter int NSW         = 21,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_map_controller_if.slave  bus,
    input  logic [NSW-1:0]       sw_i,
    output logic [DW-1:0]        rom_addr_o,
    input  logic [DW-1:0]        rom_rd_i,
    output logic [DW-1:0]        ram_addr_o,
    output logic                 ram_we_o,
    output logic                 ram_vf_o,
    output logic [DW-1:0]        ram_wd_o,
    input  logic [DW-1:0]        ram_rd_i
);

    localparam int IO_WORDS = 2 * NSW + 1;
    localparam int IOW      = $clog2(IO_WORDS);
    // Counter only has to reach DB_CYCLES-1; the flip happens on that cycle.
    localparam int CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    localparam logic [DW-1:0] ROM_LO = DW'(ROM_BASE);
    localparam logic [DW-1:0] ROM_SZ = DW'(ROM_SIZE);
    localparam logic [DW-1:0] RAM_LO = DW'(RAM_BASE);
    localparam logic [DW-1:0] RAM_SZ = DW'(RAM_SIZE);
    localparam logic [DW-1:0] IO_LO  = DW'(IO_BASE);
    localparam logic [DW-1:0] IO_SZ  = DW'(IO_WORDS);

    typedef enum logic [1:0] {
        RGN_NONE = 2'd0,
        RGN_ROM  = 2'd1,
        RGN_RAM  = 2'd2,
        RGN_IO   = 2'd3
    } region_e;

    // Address decode
    logic [DW-1:0]  rom_off;
    logic [DW-1:0]  ram_off;
    logic [DW-1:0]  io_off;
    logic [IOW-1:0] io_idx;
    region_e        region;
    logic           rd_req;

    // Response pipeline
    region_e        region_q, region_d;
    logic           rd_valid_q, rd_valid_d;
    logic           err_q, err_d;
    logic [DW-1:0]  io_word_q, io_word_d;
    logic [DW-1:0]  rd_mux;

    // Switch path
    logic [NSW-1:0] sync_q [SYNC_STAGES];
    logic [NSW-1:0] sync_out;
    logic [CW-1:0]  cnt_q [NSW];
    logic [CW-1:0]  cnt_d [NSW];
    logic [NSW-1:0] db_q, db_d;
    logic [NSW-1:0] sticky_q, sticky_d;
    logic [NSW-1:0] clr_mask;
    logic [NSW-1:0] rise;

    // Window checks use the unsigned offset so a zero base needs no lower-bound
    // compare: an address below the base wraps to a huge offset and misses.
    always_comb begin
        rom_off = bus.addr - ROM_LO;
        ram_off = bus.addr - RAM_LO;
        io_off  = bus.addr - IO_LO;
        io_idx  = io_off[IOW-1:0];
        region  = RGN_NONE;
        if (rom_off < ROM_SZ) begin
            region = RGN_ROM;
        end else if (ram_off < RAM_SZ) begin
            region = RGN_RAM;
        end else if (io_off < IO_SZ) begin
            region = RGN_IO;
        end
    end

    // A write in the same cycle as a read request takes precedence.
    assign rd_req = bus.req & ~bus.we;

    assign rom_addr_o = (region == RGN_ROM) ? rom_off : '0;
    assign ram_addr_o = (region == RGN_RAM) ? ram_off : '0;
    assign ram_we_o   = bus.we & (region == RGN_RAM);
    assign ram_vf_o   = bus.vf;
    assign ram_wd_o   = bus.wd;

    // IO read word is captured at the request edge so the response cycle only
    // has to mux; edge bits read here are cleared at that same edge.
    always_comb begin
        io_word_d = '0;
        clr_mask  = '0;
        if (rd_req && (region == RGN_IO)) begin
            for (int i = 0; i < NSW; i++) begin
                if (io_idx == IOW'(i)) begin
                    io_word_d[0] = db_q[i];
                end
                if (io_idx == IOW'(NSW + i)) begin
                    io_word_d[0] = sticky_q[i];
                    clr_mask[i]  = 1'b1;
                end
            end
            if (io_idx == IOW'(2 * NSW)) begin
                io_word_d[NSW-1:0] = db_q;
            end
        end
    end

    always_comb begin
        rd_valid_d = rd_req;
        region_d   = rd_req ? region : RGN_NONE;
        err_d      = (bus.we && (region != RGN_RAM))
                   || (rd_req && (region == RGN_NONE));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            region_q   <= RGN_NONE;
            err_q      <= 1'b0;
            io_word_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            region_q   <= region_d;
            err_q      <= err_d;
            io_word_q  <= io_word_d;
        end
    end

    // Unmapped reads keep region RGN_NONE and therefore return zero.
    always_comb begin
        rd_mux = '0;
        if (rd_valid_q) begin
            case (region_q)
                RGN_ROM: rd_mux = rom_rd_i;
                RGN_RAM: rd_mux = ram_rd_i;
                RGN_IO:  rd_mux = io_word_q;
                default: rd_mux = '0;
            endcase
        end
    end

    assign bus.rd       = rd_mux;
    assign bus.rd_valid = rd_valid_q;
    assign bus.err      = err_q;

    // Switch synchroniser
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= sw_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Debounce: count consecutive cycles where the synchronised input disagrees
    // with the debounced state; the DB_CYCLES-th disagreement flips the state.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < NSW; i++) begin
            cnt_d[i] = '0;
            if (sync_out[i] != db_q[i]) begin
                if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
                    db_d[i] = sync_out[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        rise     = db_d & ~db_q;
        // Set is applied after the clear so a simultaneous rise survives.
        sticky_d = (sticky_q & ~clr_mask) | rise;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSW; i++) begin
                cnt_q[i] <= '0;
            end
            db_q     <= '0;
            sticky_q <= '0;
        end else begin
            for (int i = 0; i < NSW; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            db_q     <= db_d;
            sticky_q <= sticky_d;
        end
    end

endmodule

// File: tb/tb_mem_map_controller.sv
// tb_mem_map_controller: directed and randomized bus traffic against a
// behavioural model of the memory map, ROM/RAM contents and switch debounce.
module tb_mem_map_controller;

    localparam int DW          = 128;
    localparam int ROM_BASE    = 0;
    localparam int ROM_SIZE    = 120000;
    localparam int RAM_BASE    = 120000;
    localparam int RAM_SIZE    = 121000;
    localparam int IO_BASE     = 241000;
    localparam int NSW         = 21;
    localparam int SYNC_STAGES = 2;
    localparam int DB_CYCLES   = 4;

    localparam int K_NONE = 0;
    localparam int K_ROM  = 1;
    localparam int K_RAM  = 2;
    localparam int K_IO   = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [NSW-1:0] sw_i;
    logic [DW-1:0]  rom_addr_o, rom_rd_i;
    logic [DW-1:0]  ram_addr_o, ram_wd_o, ram_rd_i;
    logic           ram_we_o, ram_vf_o;

    mem_map_controller_if #(.DW(DW)) bus ();

    mem_map_controller #(
        .DW(DW), .ROM_BASE(ROM_BASE), .ROM_SIZE(ROM_SIZE),
        .RAM_BASE(RAM_BASE), .RAM_SIZE(RAM_SIZE), .IO_BASE(IO_BASE),
        .NSW(NSW), .SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .sw_i(sw_i),
        .rom_addr_o(rom_addr_o), .rom_rd_i(rom_rd_i),
        .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_vf_o(ram_vf_o),
        .ram_wd_o(ram_wd_o), .ram_rd_i(ram_rd_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [NSW-1:0] m_deb, m_stk;
    int             m_run [NSW];
    logic [NSW-1:0] m_pipe [$];
    logic [DW-1:0]  ref_mem [int];
    logic [DW-1:0]  env_mem [int];
    logic [NSW-1:0] sw_cur;

    logic           exp_v, exp_err;
    logic [DW-1:0]  exp_rd;
    logic [DW-1:0]  lat_rom, lat_ram, lat_wd;
    logic           lat_we;

    function automatic logic [DW-1:0] rom_fn(input logic [DW-1:0] a);
        logic [DW-1:0] k;
        k = {4{32'h5A5A_1234}};
        return (a * 3) ^ k;
    endfunction

    function automatic logic [DW-1:0] mem_init(input int i);
        return {32'hDEAD_BEEF, 64'h0, 32'(i)};
    endfunction

    function automatic bit in_rng(input logic [DW-1:0] a, input longint base, input longint size);
        logic [DW-1:0] b;
        b = DW'(base);
        return (a >= b) && (a < b + DW'(size));
    endfunction

    function automatic int kind_of(input logic [DW-1:0] a);
        if (in_rng(a, ROM_BASE, ROM_SIZE)) return K_ROM;
        if (in_rng(a, RAM_BASE, RAM_SIZE)) return K_RAM;
        if (in_rng(a, IO_BASE, 2 * NSW + 1)) return K_IO;
        return K_NONE;
    endfunction

    function automatic logic [DW-1:0] rand_addr();
        logic [DW-1:0] a;
        case ($urandom_range(7, 0))
            0: a = DW'(ROM_BASE + $urandom_range(ROM_SIZE - 1, 0));
            1: a = DW'(ROM_BASE + ROM_SIZE - 1);
            2: a = DW'(RAM_BASE + $urandom_range(31, 0));
            3: a = DW'(RAM_BASE + RAM_SIZE - 1 - $urandom_range(1, 0));
            4, 5: a = DW'(IO_BASE + $urandom_range(2 * NSW, 0));
            6: a = DW'(IO_BASE + 2 * NSW + 1);
            default: begin
                a = {$urandom, $urandom, $urandom, $urandom};
                a[DW-1] = 1'b1;
            end
        endcase
        return a;
    endfunction

    task automatic model_reset();
        m_deb = '0;
        m_stk = '0;
        for (int i = 0; i < NSW; i++) m_run[i] = 0;
        m_pipe.delete();
        repeat (SYNC_STAGES) m_pipe.push_back('0);
        exp_v = 1'b0; exp_err = 1'b0; exp_rd = '0;
        lat_rom = '0; lat_ram = '0; lat_wd = '0; lat_we = 1'b0;
    endtask

    // Drive one access, check the combinational RAM/ROM side, then advance the
    // model by the coming clock edge.
    task automatic phase_a(input logic r, input logic w, input logic v,
                           input logic [DW-1:0] a, input logic [DW-1:0] d);
        int             k, o;
        logic [NSW-1:0] seen;
        bus.req = r; bus.we = w; bus.vf = v; bus.addr = a; bus.wd = d; sw_i = sw_cur;
        #1;
        k = kind_of(a);
        check_val("rom_addr", rom_addr_o, (k == K_ROM) ? a - DW'(ROM_BASE) : '0);
        check_val("ram_addr", ram_addr_o, (k == K_RAM) ? a - DW'(RAM_BASE) : '0);
        check_val("ram_we", DW'(ram_we_o), DW'(w && (k == K_RAM)));
        check_val("ram_vf", DW'(ram_vf_o), DW'(v));
        check_val("ram_wd", ram_wd_o, d);
        lat_rom = rom_addr_o; lat_ram = ram_addr_o; lat_we = ram_we_o; lat_wd = ram_wd_o;

        exp_v   = r && !w;
        exp_err = (w && (k != K_RAM)) || (r && !w && (k == K_NONE));
        exp_rd  = '0;
        if (exp_v) begin
            if (k == K_ROM) begin
                exp_rd = rom_fn(a - DW'(ROM_BASE));
            end else if (k == K_RAM) begin
                o = int'(32'(a - DW'(RAM_BASE)));
                exp_rd = ref_mem.exists(o) ? ref_mem[o] : mem_init(o);
            end else if (k == K_IO) begin
                o = int'(32'(a - DW'(IO_BASE)));
                if (o < NSW) begin
                    exp_rd = DW'(m_deb[o]);
                end else if (o < 2 * NSW) begin
                    exp_rd = DW'(m_stk[o - NSW]);
                    m_stk[o - NSW] = 1'b0;
                end else begin
                    exp_rd = DW'(m_deb);
                end
            end
        end
        if (w && (k == K_RAM)) begin
            ref_mem[int'(32'(a - DW'(RAM_BASE)))] = d;
        end
        seen = m_pipe.pop_front();
        m_pipe.push_back(sw_cur);
        for (int i = 0; i < NSW; i++) begin
            if (seen[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == DB_CYCLES) begin
                    m_deb[i] = seen[i];
                    m_run[i] = 0;
                    if (seen[i]) m_stk[i] = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
    endtask

    // After the edge: act as the synchronous ROM/RAM, then check the response.
    task automatic phase_b();
        int ri;
        @(negedge clk);
        ri = int'(lat_ram[31:0]);
        rom_rd_i = rom_fn(lat_rom);
        ram_rd_i = env_mem.exists(ri) ? env_mem[ri] : mem_init(ri);
        if (lat_we) env_mem[ri] = lat_wd;
        #1;
        check_val("rd_valid", DW'(bus.rd_valid), DW'(exp_v));
        check_val("rd", bus.rd, exp_rd);
        check_val("err", DW'(bus.err), DW'(exp_err));
    endtask

    task automatic do_cycle(input logic r, input logic w, input logic v,
                            input logic [DW-1:0] a, input logic [DW-1:0] d);
        phase_a(r, w, v, a, d);
        phase_b();
    endtask

    initial begin
        int            op, b;
        logic [DW-1:0] a, d;

        rst = 1'b1;
        bus.req = 1'b0; bus.we = 1'b0; bus.vf = 1'b0; bus.addr = '0; bus.wd = '0;
        sw_cur = '0; sw_i = '0;
        rom_rd_i = {4{32'hFFFF_0001}};
        ram_rd_i = {4{32'hFFFF_0002}};
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_val("reset rd_valid", DW'(bus.rd_valid), '0);
        check_val("reset err", DW'(bus.err), '0);
        check_val("reset rd", bus.rd, '0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // ROM read at address 5
        do_cycle(1'b1, 1'b0, 1'b0, DW'(5), '0);
        // RAM write, ROM write error, RAM readback
        do_cycle(1'b0, 1'b1, 1'b1, DW'(120010), DW'(32'h55));
        do_cycle(1'b0, 1'b1, 1'b0, DW'(3), DW'(32'h77));
        do_cycle(1'b1, 1'b0, 1'b0, DW'(120010), '0);

        // Switch 4 rises; poll its debounced bit across the settling boundary
        sw_cur[4] = 1'b1;
        repeat (SYNC_STAGES + DB_CYCLES + 2) do_cycle(1'b1, 1'b0, 1'b0, DW'(IO_BASE + 4), '0);
        do_cycle(1'b1, 1'b0, 1'b0, DW'(IO_BASE + NSW + 4), '0);
        do_cycle(1'b1, 1'b0, 1'b0, DW'(IO_BASE + NSW + 4), '0);
        do_cycle(1'b1, 1'b0, 1'b0, DW'(IO_BASE + 2 * NSW), '0);

        // Switch 0 glitch one cycle short of the debounce count
        sw_cur[0] = 1'b1;
        repeat (DB_CYCLES - 1) do_cycle(1'b0, 1'b0, 1'b0, '0, '0);
        sw_cur[0] = 1'b0;
        repeat (SYNC_STAGES + DB_CYCLES + 2) do_cycle(1'b1, 1'b0, 1'b0, DW'(IO_BASE), '0);
        do_cycle(1'b1, 1'b0, 1'b0, DW'(IO_BASE + NSW), '0);

        // Unmapped read; simultaneous req+we to RAM; window boundaries
        do_cycle(1'b1, 1'b0, 1'b0, DW'(300000), '0);
        do_cycle(1'b1, 1'b1, 1'b0, DW'(RAM_BASE + 77), DW'(32'hABC));
        do_cycle(1'b1, 1'b0, 1'b0, DW'(RAM_BASE + 77), '0);
        do_cycle(1'b1, 1'b0, 1'b0, DW'(ROM_BASE + ROM_SIZE - 1), '0);
        do_cycle(1'b1, 1'b0, 1'b0, DW'(RAM_BASE + RAM_SIZE - 1), '0);
        do_cycle(1'b1, 1'b0, 1'b0, DW'(IO_BASE + 2 * NSW + 1), '0);
        do_cycle(1'b0, 1'b1, 1'b0, DW'(IO_BASE + 1), DW'(1));

        // Back-to-back reads
        for (int n = 0; n < 20; n++) do_cycle(1'b1, 1'b0, 1'b0, rand_addr(), '0);

        // Random traffic with switch activity
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(5, 0) == 0) begin
                b = $urandom_range(5, 0);
                sw_cur[b] = ~sw_cur[b];
            end
            op = $urandom_range(7, 0);
            a  = rand_addr();
            d  = {$urandom, $urandom, $urandom, $urandom};
            case (op)
                0, 1, 2: do_cycle(1'b1, 1'b0, 1'($urandom), a, d);
                3, 4:    do_cycle(1'b0, 1'b1, 1'($urandom), a, d);
                5:       do_cycle(1'b1, 1'b1, 1'($urandom), a, d);
                6:       do_cycle(1'b0, 1'b0, 1'b0, a, d);
                default: do_cycle(1'b1, 1'b0, 1'b0, DW'(IO_BASE + $urandom_range(2 * NSW, 0)), d);
            endcase
        end

        // Reset with a read in flight and edge bit 2 pending
        sw_cur = '0;
        repeat (SYNC_STAGES + DB_CYCLES + 2) do_cycle(1'b0, 1'b0, 1'b0, '0, '0);
        do_cycle(1'b1, 1'b0, 1'b0, DW'(IO_BASE + NSW + 2), '0);
        sw_cur[2] = 1'b1;
        repeat (SYNC_STAGES + DB_CYCLES + 2) do_cycle(1'b0, 1'b0, 1'b0, '0, '0);
        phase_a(1'b1, 1'b0, 1'b0, DW'(300000), '0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("rst rd_valid", DW'(bus.rd_valid), '0);
        check_val("rst err", DW'(bus.err), '0);
        check_val("rst rd", bus.rd, '0);
        bus.req = 1'b0; bus.we = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        do_cycle(1'b1, 1'b0, 1'b0, DW'(IO_BASE + NSW + 2), '0);
        do_cycle(1'b1, 1'b0, 1'b0, DW'(IO_BASE + 2 * NSW), '0);
        do_cycle(1'b1, 1'b0, 1'b0, DW'(5), '0);
        repeat (SYNC_STAGES + DB_CYCLES + 2) do_cycle(1'b1, 1'b0, 1'b0, DW'(IO_BASE + 2), '0);
        do_cycle(1'b1, 1'b0, 1'b0, DW'(IO_BASE + NSW + 2), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
